mult_arb: RTL
=============

MULT_ARB -- requirements
Module: mult_arb

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; product width is 2*WIDTH.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester 0 / 1 presents an operand pair.
REQ-005 req0_a, req0_b / req1_a, req1_b  input  WIDTH  unsigned operands, requester 0 / 1.
REQ-006 req0_ready / req1_ready  output  1  request accepted this cycle (handshake = valid & ready).
REQ-007 rsp0_valid / rsp1_valid  output  1  one-cycle pulse, product for requester 0 / 1 is valid.
REQ-008 rsp0_p / rsp1_p  output  2*WIDTH  product for requester 0 / 1; meaningful only while the matching rsp valid is high.
REQ-009 in_flight  output  2  number of accepted operations not yet responded (0..2).

Function
REQ-010 The block SHALL share one WIDTHxWIDTH unsigned multiplier between two requesters, accepting at most one request per cycle.
REQ-011 At most one of req0_ready, req1_ready SHALL be high in any cycle; reqN_ready SHALL be high only when reqN_valid is high and requester N wins arbitration.
REQ-012 One valid requester SHALL always be granted; with both valid, round-robin SHALL grant the requester not granted at the last handshake.
REQ-013 The round-robin pointer SHALL update only on a handshake; idle cycles SHALL not change it.
REQ-014 Pipeline: handshake in cycle N registers operands and a 1-bit requester tag; product registered at end of cycle N+1; rspX_valid high in cycle N+2 only (fixed latency 2).
REQ-015 Back-to-back handshakes SHALL give back-to-back responses in acceptance order with correct tags; no bubbles inserted.
REQ-016 Responses have no backpressure; the requester SHALL not be allowed to stall a response, and an un-consumed response is lost.
REQ-017 rsp0_p / rsp1_p SHALL be full-width products, no truncation; 255*255 = 65025 (16'hFE01) at WIDTH=8.
REQ-018 in_flight SHALL equal handshakes in the last two cycles; +1 on handshake, -1 on response, unchanged when both occur together.
REQ-019 Operand inputs SHALL be sampled only on handshake; changes on non-handshake cycles SHALL not affect any result.

Reset
REQ-020 While rst_n is low at a clock edge: rsp0_valid, rsp1_valid = 0; rsp0_p, rsp1_p = 0; in_flight = 0; pipeline valid bits cleared; round-robin pointer set so requester 0 wins the first tie.
REQ-021 req0_ready and req1_ready SHALL be 0 in any cycle in which rst_n is low.
REQ-022 Reset mid-operation SHALL discard all in-flight operations; no rsp valid SHALL assert for an operation accepted before the reset.

Configuration
REQ-023 Macro MULT_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both valid; round-robin pointer absent; requester 1 may starve.
REQ-024 Macro MULT_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-012/013 (default build).

Structure
REQ-025 A shared package mult_pkg SHALL hold the WIDTH default, requester-ID type (1 bit) and the latency constant (2).
REQ-026 The multiplier SHALL be a sub-module mult_core (registered operands, registered 2*WIDTH product, valid/tag pipeline); mult_arb holds arbitration, pointer, in_flight and response demux.

Verification
REQ-027 Single: req0 a=3, b=5 in cycle 0 -> req0_ready=1 cycle 0; rsp0_valid=1, rsp0_p=15 cycle 2 only; rsp1_valid stays 0.
REQ-028 Contention: both valid for 4 cycles after reset (req0 2*2, req1 3*3) -> grants 0,1,0,1; responses cycles 2..5: rsp0=4, rsp1=9, rsp0=4, rsp1=9.
REQ-029 Boundary: req1 a=255, b=255 -> rsp1_p=16'hFE01; a=0, b=200 -> rsp1_p=0.
REQ-030 Streaming: req0 continuous for 5 cycles -> in_flight 0,1,2,2,2,2,1,0; 5 consecutive rsp0_valid pulses.
REQ-031 Reset mid-flight: handshake cycle 0, rst_n low cycle 1 -> no rsp valid in cycles 1..4; in_flight=0 after reset; next tie grants requester 0.
REQ-032 MULT_ARB_FIXED_PRIO_EN defined, both valid 4 cycles -> req0_ready=1 all 4 cycles, req1_ready=0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the two-requester shared multiplier (mult_arb / mult_core).
package mult_pkg;

  localparam int MULT_WIDTH   = 8;
  localparam int MULT_LATENCY = 2;

  typedef logic req_id_t;

endpackage

// File: rtl/mult_core.sv
// Two-stage unsigned multiplier: registered operands, then registered full-width product,
// with a valid/tag pipeline travelling alongside so responses can be routed back.
module mult_core
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  input  logic [WIDTH-1:0]   in_a_i,
  input  logic [WIDTH-1:0]   in_b_i,
  input  req_id_t            in_tag_i,
  output logic               out_valid_o,
  output logic [2*WIDTH-1:0] out_p_o,
  output req_id_t            out_tag_o
);

  logic [WIDTH-1:0]   a_q, b_q;
  logic               stage1_valid_q;
  req_id_t            stage1_tag_q;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               out_valid_q;
  req_id_t            out_tag_q;

  // Zero-extend before multiplying so the full 2*WIDTH product is kept.
  assign p_d = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q            <= '0;
      b_q            <= '0;
      stage1_valid_q <= 1'b0;
      stage1_tag_q   <= 1'b0;
      p_q            <= '0;
      out_valid_q    <= 1'b0;
      out_tag_q      <= 1'b0;
    end else begin
      stage1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        a_q          <= in_a_i;
        b_q          <= in_b_i;
        stage1_tag_q <= in_tag_i;
      end
      out_valid_q <= stage1_valid_q;
      out_tag_q   <= stage1_tag_q;
      if (stage1_valid_q) begin
        p_q <= p_d;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_p_o     = p_q;
  assign out_tag_o   = out_tag_q;

endmodule

// File: rtl/mult_arb.sv
// Two-requester front end for a shared multiplier: arbitration, in-flight count, response demux.
// Define MULT_ARB_FIXED_PRIO_EN for fixed priority to requester 0; default is round-robin.
module mult_arb
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req0_ready,
  output logic               req1_ready,
  output logic               rsp0_valid,
  output logic [2*WIDTH-1:0] rsp0_p,
  output logic               rsp1_valid,
  output logic [2*WIDTH-1:0] rsp1_p,
  output logic [1:0]         in_flight
);

  logic               grant0, grant1, hs;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic               core_valid;
  logic [2*WIDTH-1:0] core_p;
  req_id_t            core_tag;
  logic [1:0]         in_flight_q, in_flight_d;

`ifdef MULT_ARB_FIXED_PRIO_EN
  assign grant0 = req0_valid;
  assign grant1 = req1_valid & ~req0_valid;
`else
  req_id_t last_q;

  // last_q holds the requester granted at the last handshake; the other one wins a tie.
  assign grant0 = req0_valid & (~req1_valid | last_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (hs) begin
      last_q <= req1_ready;
    end
  end
`endif

  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;
  assign hs         = req0_ready | req1_ready;
  assign sel_a      = req1_ready ? req1_a : req0_a;
  assign sel_b      = req1_ready ? req1_b : req0_b;

  mult_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (hs),
    .in_a_i     (sel_a),
    .in_b_i     (sel_b),
    .in_tag_i   (req1_ready),
    .out_valid_o(core_valid),
    .out_p_o    (core_p),
    .out_tag_o  (core_tag)
  );

  // A response leaving this cycle and a new handshake cancel out.
  assign in_flight_d = in_flight_q + {1'b0, hs} - {1'b0, core_valid};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_flight_q <= 2'd0;
    end else begin
      in_flight_q <= in_flight_d;
    end
  end

  assign in_flight  = in_flight_q;
  assign rsp0_valid = core_valid & (core_tag == 1'b0);
  assign rsp1_valid = core_valid & (core_tag == 1'b1);
  assign rsp0_p     = rsp0_valid ? core_p : '0;
  assign rsp1_p     = rsp1_valid ? core_p : '0;

endmodule
